// File: rtl/shift_seq_ctrl.sv
// Iterative 16-bit shift/rotate sequencer: 4-bit steps first, then the residual 0-3 bits.
// Optional macro SHIFT_SEQ_FAST_RESID_EN: residual bits applied in a single cycle.
module shift_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [3:0]  amt,
  input  logic [15:0] dataIn,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] work;
  logic [1:0]  op_q;
  logic [1:0]  cnt4;
  logic [1:0]  cnt1;

  function automatic logic [15:0] step4(input logic [15:0] w, input logic [1:0] o);
    case (o)
      2'b00:   step4 = {w[11:0], w[15:12]};
      2'b01:   step4 = {w[11:0], 4'b0};
      2'b10:   step4 = {{4{w[15]}}, w[15:4]};
      default: step4 = {4'b0, w[15:4]};
    endcase
  endfunction

  function automatic logic [15:0] step1(input logic [15:0] w, input logic [1:0] o);
    case (o)
      2'b00:   step1 = {w[14:0], w[15]};
      2'b01:   step1 = {w[14:0], 1'b0};
      2'b10:   step1 = {w[15], w[15:1]};
      default: step1 = {1'b0, w[15:1]};
    endcase
  endfunction

`ifdef SHIFT_SEQ_FAST_RESID_EN
  function automatic logic [15:0] step2(input logic [15:0] w, input logic [1:0] o);
    case (o)
      2'b00:   step2 = {w[13:0], w[15:14]};
      2'b01:   step2 = {w[13:0], 2'b0};
      2'b10:   step2 = {{2{w[15]}}, w[15:2]};
      default: step2 = {2'b0, w[15:2]};
    endcase
  endfunction

  // Residual of 1-3 bits: a 1-bit stage followed by a 2-bit stage.
  function automatic logic [15:0] resid(input logic [15:0] w, input logic [1:0] o,
                                        input logic [1:0] n);
    logic [15:0] r;
    r = w;
    if (n[0]) r = step1(r, o);
    if (n[1]) r = step2(r, o);
    resid = r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= 16'h0000;
      work  <= 16'h0000;
      op_q  <= 2'b00;
      cnt4  <= 2'd0;
      cnt1  <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= dataIn;
            op_q  <= op;
            cnt4  <= amt[3:2];
            cnt1  <= amt[1:0];
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: begin
          if (cnt4 != 2'd0) begin
            work <= step4(work, op_q);
            cnt4 <= cnt4 - 2'd1;
          end else if (cnt1 != 2'd0) begin
`ifdef SHIFT_SEQ_FAST_RESID_EN
            work <= resid(work, op_q, cnt1);
            cnt1 <= 2'd0;
`else
            work <= step1(work, op_q);
            cnt1 <= cnt1 - 2'd1;
`endif
          end else begin
            // All steps applied: publish result; a new request may be taken next edge.
            out   <= work;
            done  <= 1'b1;
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized traffic vs. a reference model.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic [15:0] dataIn;
  logic        ready, busy, done;
  logic [15:0] out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] prev_out;

  shift_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt(amt), .dataIn(dataIn),
    .ready(ready), .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [1:0] o, input logic [3:0] a,
                                            input logic [15:0] d);
    logic [31:0]        t;
    logic signed [15:0] s;
    case (o)
      2'b00: begin t = {d, d} << a; model_res = t[31:16]; end
      2'b01: model_res = d << a;
      2'b10: begin s = d; model_res = s >>> a; end
      default: model_res = d >> a;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] a);
    int steps;
`ifdef SHIFT_SEQ_FAST_RESID_EN
    steps = int'(a[3:2]) + ((a[1:0] != 2'd0) ? 1 : 0);
`else
    steps = int'(a[3:2]) + int'(a[1:0]);
`endif
    model_lat = steps + 1;
  endfunction

  // Drive a request now and return #1 after its accept edge.
  task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
    start = 1'b1; op = o; amt = a; dataIn = d;
    @(posedge clk); #1;
    start  = 1'b0;
    op     = 2'($urandom_range(3, 0));
    amt    = 4'($urandom_range(15, 0));
    dataIn = 16'($urandom);
  endtask

  // Count edges from the accept edge until done; cyc0 edges have already elapsed.
  task automatic wait_done(input string tag, input int cyc0, input int lat, input logic [15:0] exp);
    int cyc;
    bit got;
    cyc = cyc0;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1;
      else begin
        chk({tag, "_run_flags"}, {busy, ready}, 2'b10);
        chk({tag, "_out_hold"}, out, prev_out);
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_out"}, out, exp);
      chk({tag, "_done_flags"}, {busy, ready}, 2'b01);
      prev_out = exp;
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [3:0]  ra;
    logic [15:0] rd;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; amt = 4'd0; dataIn = 16'h0;
    prev_out = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {ready, busy, done}, 3'b100);
    chk("rst_out", out, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_flags", {ready, busy, done}, 3'b100);
    chk("idle_out", out, 16'h0000);

    issue(2'b01, 4'd4, 16'h1234);
    wait_done("sll4", 0, 2, 16'h2340);
    issue(2'b00, 4'd5, 16'h8001);
    wait_done("rol5", 0, model_lat(4'd5), 16'h0030);
    issue(2'b10, 4'd15, 16'h8000);
    wait_done("sra15", 0, model_lat(4'd15), 16'hFFFF);

    // Start while busy must be ignored; start in the done cycle must be accepted.
    issue(2'b11, 4'd6, 16'hF00F);
    @(negedge clk); start = 1'b1; op = 2'b01; amt = 4'd1; dataIn = 16'h0001;
    @(negedge clk); start = 1'b0;
    wait_done("srl6", 1, model_lat(4'd6), 16'h03C0);
    issue(2'b01, 4'd1, 16'h0001);
    wait_done("b2b", 0, 2, 16'h0002);

    ro = 2'($urandom_range(3, 0));
    issue(ro, 4'd0, 16'hA5A5);
    wait_done("amt0", 0, 1, 16'hA5A5);

    // Reset in the second RUN cycle abandons the request.
    @(posedge clk); #1;
    issue(2'b01, 4'd9, 16'hFFFF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", out, 16'h0000);
    chk("midrst_flags", {ready, busy, done}, 3'b100);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_nodone", done, 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    prev_out = 16'h0000;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {ready, busy, done}, 3'b100);
      chk("post_rst_out", out, 16'h0000);
    end

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(3, 0));
      ra = 4'($urandom_range(15, 0));
      rd = 16'($urandom);
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) begin
          @(posedge clk); #1;
          chk("rnd_idle", {ready, busy, done, out}, {3'b100, prev_out});
        end
      end
      issue(ro, ra, rd);
      wait_done("rnd", 0, model_lat(ra), model_res(ro, ra, rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
